// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  // Loader states. CSUM is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  // Width of the little-endian word-count header.
  localparam int HDR_W = 16;

  // Bytes per instruction word.
  localparam int WORD_BYTES = 4;

  // Byte address of a given word index relative to a base address.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [HDR_W-1:0] idx);
    return base + (32'(idx) * 32'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer. Each accepted byte lands in its own
// lane; on the fourth byte a registered one-cycle word_valid pulse is raised
// alongside the assembled word. Cleared synchronously by 'clear'.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0] byte_idx_reg;
  logic       word_valid_reg;
  logic [7:0] lane_reg [WORD_BYTES];

  // Byte index walks 0..3 per accepted byte; word pulse fires after byte 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_reg   <= 2'd0;
      word_valid_reg <= 1'b0;
    end else begin
      word_valid_reg <= 1'b0;
      if (clear) begin
        byte_idx_reg <= 2'd0;
      end else if (byte_valid) begin
        byte_idx_reg   <= byte_idx_reg + 2'd1;
        word_valid_reg <= (byte_idx_reg == 2'd3);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      // Capture the byte destined for this lane (byte 0 -> bits [7:0]).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg[gi] <= 8'h00;
        end else if (clear) begin
          lane_reg[gi] <= 8'h00;
        end else if (byte_valid && (byte_idx_reg == 2'(gi))) begin
          lane_reg[gi] <= byte_data;
        end
      end
      assign word_data[8*gi +: 8] = lane_reg[gi];
    end
  endgenerate

  assign byte_idx   = byte_idx_reg;
  assign word_valid = word_valid_reg;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: header (16-bit word count, LE), then
// N little-endian words written to instruction memory at word-aligned
// addresses, holding the core in reset while loading.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam logic [HDR_W-1:0] DEPTH_N = HDR_W'(DEPTH);

  state_t           state_reg;
  logic [HDR_W-1:0] count_reg;
  logic [HDR_W-1:0] word_idx_reg;
  logic [31:0]      waddr_reg;
  logic             cpu_hold_reg;
  logic             done_reg;
  logic             err_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_reg;
`endif

  logic             xfer;
  logic             start_ok;
  logic             data_byte;
  logic [HDR_W-1:0] hdr_count;
  logic [1:0]       byte_idx;

  assign in_ready  = (state_reg == ST_HDR0) || (state_reg == ST_HDR1) ||
                     (state_reg == ST_DATA) || (state_reg == ST_CSUM);
  assign xfer      = in_valid && in_ready;
  assign start_ok  = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                               (state_reg == ST_ERR));
  assign data_byte = xfer && (state_reg == ST_DATA);
  assign hdr_count = {in_data, count_reg[7:0]};

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .byte_valid (data_byte),
    .byte_data  (in_data),
    .byte_idx   (byte_idx),
    .word_valid (we),
    .word_data  (wdata)
  );

  // Frame sequencing, write addressing and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      word_idx_reg <= '0;
      waddr_reg    <= BASE_ADDR;
      cpu_hold_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg     <= 8'h00;
`endif
    end else if (start_ok) begin
      state_reg    <= ST_HDR0;
      word_idx_reg <= '0;
      cpu_hold_reg <= 1'b1;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg     <= 8'h00;
`endif
    end else begin
      case (state_reg)
        ST_HDR0: begin
          if (xfer) begin
            count_reg[7:0] <= in_data;
            state_reg      <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (xfer) begin
            count_reg <= hdr_count;
            if (hdr_count > DEPTH_N) begin
              state_reg    <= ST_ERR;
              err_reg      <= 1'b1;
              cpu_hold_reg <= 1'b0;
            end else if (hdr_count == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_reg    <= ST_CSUM;
`else
              state_reg    <= ST_DONE;
              done_reg     <= 1'b1;
              cpu_hold_reg <= 1'b0;
`endif
            end else begin
              state_reg <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg <= csum_reg ^ in_data;
`endif
            if (byte_idx == 2'd3) begin
              waddr_reg    <= word_byte_addr(BASE_ADDR, word_idx_reg);
              word_idx_reg <= word_idx_reg + 1'b1;
              if (word_idx_reg == count_reg - 1'b1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_reg    <= ST_CSUM;
`else
                state_reg    <= ST_DONE;
                done_reg     <= 1'b1;
                cpu_hold_reg <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (xfer) begin
            cpu_hold_reg <= 1'b0;
            if (in_data == csum_reg) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_ERR;
              err_reg   <= 1'b1;
            end
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign waddr        = waddr_reg;
  assign cpu_hold     = cpu_hold_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign words_loaded = word_idx_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. A frame-level reference model builds
// each byte stream from a list of words and predicts writes and final status.
// Honours IMEM_LOADER_CHECKSUM_EN for the trailing checksum byte.
module tb_imem_loader;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  logic [31:0] exp_words[$];

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Record every memory write seen by the instruction memory.
  always @(negedge clk) begin
    if (rst_n && we) begin
      mon_addr.push_back(waddr);
      mon_data.push_back(wdata);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic fill_random(input int n);
    exp_words.delete();
    for (int i = 0; i < n; i++) exp_words.push_back($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Offer one byte after a random idle gap; returns just after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    int w;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    else @(posedge clk);
  endtask

  // Run one complete frame announcing n words; payload comes from exp_words.
  task automatic run_load(input int n, input int gap_max, input bit corrupt, input int poke_at);
    logic [15:0] hdr;
    logic [7:0]  b;
    logic [7:0]  x;
    bit          exp_err;
    int          exp_wl;
    hdr = 16'(n);
    x   = 8'h00;
    exp_err = (n > DEPTH);
    exp_wl  = exp_err ? 0 : n;
    mon_addr.delete();
    mon_data.delete();

    pulse_start();
    check("start_ready", 32'(in_ready), 32'd1);
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_wl", 32'(words_loaded), 32'd0);
    check("start_done", 32'(done), 32'd0);
    check("start_err", 32'(err), 32'd0);

    send_byte(hdr[7:0], gap_max);
    send_byte(hdr[15:8], gap_max);
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          b = exp_words[i][8*k +: 8];
          x = x ^ b;
          if (i * 4 + k == poke_at) begin
            pulse_start();
            check("busy_start_ready", 32'(in_ready), 32'd1);
            check("busy_start_hold", 32'(cpu_hold), 32'd1);
            check("busy_start_wl", 32'(words_loaded), 32'(i));
          end
          send_byte(b, gap_max);
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(corrupt ? (x ^ 8'h01) : x, gap_max);
      exp_err = corrupt;
`endif
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("end_done", 32'(done), 32'(!exp_err));
    check("end_err", 32'(err), 32'(exp_err));
    check("end_hold", 32'(cpu_hold), 32'd0);
    check("end_ready", 32'(in_ready), 32'd0);
    check("end_wl", 32'(words_loaded), 32'(exp_wl));
    repeat (3) @(negedge clk);
    check("write_count", 32'(mon_addr.size()), 32'(exp_wl));
    for (int i = 0; i < exp_wl && i < mon_addr.size(); i++) begin
      check("waddr", mon_addr[i], BASE + 32'(i * 4));
      check("wdata", mon_data[i], exp_words[i]);
    end
    $display("load n=%0d gap=%0d corrupt=%0d writes=%0d done=%0d err=%0d",
             n, gap_max, corrupt, mon_addr.size(), done, err);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_waddr", waddr, BASE);
    check("rst_wdata", wdata, 32'd0);
    check("rst_wl", 32'(words_loaded), 32'd0);
    rst_n = 1'b1;
    $display("reset released");

    // Basic two-word load, back-to-back bytes
    exp_words.delete();
    exp_words.push_back(32'hFFC4_A303);
    exp_words.push_back(32'h0064_A423);
    run_load(2, 0, 1'b0, -1);

    // Throttled four-word load with random valid gaps
    fill_random(4);
    run_load(4, 3, 1'b0, -1);

    // Header exceeding DEPTH
    fill_random(0);
    run_load(DEPTH + 1, 0, 1'b0, -1);

    // Empty frame
    run_load(0, 1, 1'b0, -1);

    // Full-depth frame
    fill_random(DEPTH);
    run_load(DEPTH, 1, 1'b0, -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match and mismatch on a single word
    exp_words.delete();
    exp_words.push_back(32'h0062_E233);
    run_load(1, 0, 1'b0, -1);
    run_load(1, 2, 1'b1, -1);
`endif

    // Reset after two payload bytes of the first word
    mon_addr.delete();
    mon_data.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_we", 32'(we), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_waddr", waddr, BASE);
    check("midrst_wdata", wdata, 32'd0);
    check("midrst_wl", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_writes", 32'(mon_addr.size()), 32'd0);
    $display("reset mid-word applied");
    fill_random(3);
    run_load(3, 2, 1'b0, -1);

    // Start while busy is ignored, then restart from DONE
    fill_random(3);
    run_load(3, 1, 1'b0, 6);
    fill_random(2);
    run_load(2, 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
